// File: rtl/mem_responder_pkg.sv
// Shared state encoding and MMIO address map for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] MMIO_OUT_ADDR = 16'hFFF0;
  localparam logic [15:0] MMIO_IN_ADDR  = 16'hFFF1;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath strobes and the memory responder.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              MemR;
  logic              MemW;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic [DATA_W-1:0] RData;
  logic              Ready;
  logic              Busy;
  logic              Err;

  modport master (output MemR, MemW, Addr, WData, input RData, Ready, Busy, Err);
  modport slave  (input MemR, MemW, Addr, WData, output RData, Ready, Busy, Err);
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, 2**DEPTH_LOG2 x DATA_W, registered read.
module mem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: IDLE -> WAIT -> RESP FSM with WAIT_STATES latency over a word RAM.
// Optional MMIO registers at 16'hFFF0/16'hFFF1 are built when MEM_MMIO_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  mem_responder_if.slave    bus
`ifdef MEM_MMIO_EN
  ,
  output logic [DATA_W-1:0] io_out,
  input  logic [DATA_W-1:0] io_in
`endif
);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, ram_rdata, oor_rdata;
  logic              rd_q, wr_q, err_q, rd_ram_q;
  logic              req, access, ram_we;
  logic              cur_rd, cur_wr, is_rd, is_wr, in_range, mmio_ok, illegal;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  assign req = bus.MemR | bus.MemW;

  // In IDLE the live bus is the request (zero-wait access edge); afterwards the latched copy is.
  assign cur_rd    = (state == IDLE) ? bus.MemR  : rd_q;
  assign cur_wr    = (state == IDLE) ? bus.MemW  : wr_q;
  assign cur_addr  = (state == IDLE) ? bus.Addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.WData : wdata_q;

  assign is_rd    = cur_rd & ~cur_wr;
  assign is_wr    = cur_wr & ~cur_rd;
  assign in_range = (cur_addr[ADDR_W-1:DEPTH_LOG2] == '0);

  always_comb begin
    mmio_ok   = 1'b0;
    oor_rdata = '0;
`ifdef MEM_MMIO_EN
    mmio_ok = (is_wr & (cur_addr == ADDR_W'(MMIO_OUT_ADDR))) |
              (is_rd & ((cur_addr == ADDR_W'(MMIO_OUT_ADDR)) | (cur_addr == ADDR_W'(MMIO_IN_ADDR))));
    if (cur_addr == ADDR_W'(MMIO_IN_ADDR))       oor_rdata = io_in;
    else if (cur_addr == ADDR_W'(MMIO_OUT_ADDR)) oor_rdata = io_out;
`endif
  end

  assign illegal = (cur_rd & cur_wr) | (~in_range & ~mmio_ok);
  assign access  = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && (cnt == 4'd1));
  // A reset landing on the access edge discards the pending write.
  assign ram_we  = access & ~Reset & is_wr & in_range;

  mem_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (cur_addr[DEPTH_LOG2-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy  = (state != IDLE);
    bus.Ready = (state == RESP);
    bus.Err   = (state == RESP) & err_q;
    // RAM read data lives in the array's output register during RESP, then moves to rdata_q.
    bus.RData = ((state == RESP) && rd_ram_q) ? ram_rdata : rdata_q;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      rd_ram_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if ((state == IDLE) && req) begin
        addr_q  <= bus.Addr;
        wdata_q <= bus.WData;
        rd_q    <= bus.MemR;
        wr_q    <= bus.MemW;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q    <= illegal;
        rd_ram_q <= is_rd & in_range;
        if (is_rd && !in_range) rdata_q <= oor_rdata;
      end
      if ((state == RESP) && rd_ram_q) rdata_q <= ram_rdata;
    end
  end

`ifdef MEM_MMIO_EN
  always_ff @(posedge CLK) begin
    if (Reset) io_out <= '0;
    else if (access && is_wr && (cur_addr == ADDR_W'(MMIO_OUT_ADDR))) io_out <= cur_wdata;
  end
`endif

endmodule
